// File: rtl/piso_register_if.sv
// Handshake/bus bundle for the parallel-in/serial-out unload register.
// The master loads words and consumes the serial stream; the slave is the register.
interface piso_register_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             done;

    modport master (
        output enable,
        output data,
        output sout_ready,
        input  out,
        input  busy,
        input  sout,
        input  sout_valid,
        input  done
    );

    modport slave (
        input  enable,
        input  data,
        input  sout_ready,
        output out,
        output busy,
        output sout,
        output sout_valid,
        output done
    );
endinterface

// File: rtl/piso_register.sv
// Parallel-in/serial-out unload register: captures a word on enable while idle,
// then streams it MSB-first, one bit per valid/ready handshake, ending with a done pulse.
module piso_register #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    piso_register_if.slave       bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // An unknown enable falls to the else branch, so only a clean 1 loads.
                if (bus.enable) begin
                    shreg_d = bus.data;
                    out_d   = bus.data;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // sout_valid is implied by this state, so ready alone completes a transfer.
                if (bus.sout_ready) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output comes straight from a flop or a state decode.
    assign bus.out        = out_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.sout_valid = (state_q == ST_SHIFT);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.sout       = shreg_q[WIDTH-1];

endmodule

// File: tb/tb_piso_register.sv
// Directed bench for piso_register: expected serial bits are queued at load time
// and popped at each handshake; control outputs are checked 1 ns after clock edges.
module tb_piso_register;
    localparam int W = 8;

    logic clk   = 1'b1;
    logic rst_n = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    logic exp_q[$];

    piso_register_if #(.WIDTH(W)) bus ();

    piso_register #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] d);
        bus.enable = 1'b1;
        bus.data   = d;
        tick();
        bus.enable = 1'b0;
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
        chk("load_out", 32'(bus.out), 32'(d));
        chk("load_busy", 32'(bus.busy), 32'd1);
        chk("load_valid", 32'(bus.sout_valid), 32'd1);
    endtask

    // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1 repeating.
    // jam: hold enable=1/data=55 throughout to prove loads are ignored while busy.
    task automatic stream(input int mode, input bit jam, input int nbits);
        int   got = 0;
        int   guard = 0;
        int   k = 0;
        logic hold = 1'b0;
        logic prev = 1'b0;
        logic rdy;
        logic e;
        while (got < nbits && guard < 100) begin
            guard++;
            rdy = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            chk("shift_valid", 32'(bus.sout_valid), 32'd1);
            chk("shift_done_low", 32'(bus.done), 32'd0);
            if (hold) chk("sout_stable", 32'(bus.sout), 32'(prev));
            if (jam) begin
                bus.enable = 1'b1;
                bus.data   = 8'h55;
            end
            bus.sout_ready = rdy;
            if (rdy) begin
                e = exp_q.pop_front();
                chk("sout_bit", 32'(bus.sout), 32'(e));
                got++;
                hold = 1'b0;
            end else begin
                hold = 1'b1;
                prev = bus.sout;
            end
            k++;
            tick();
        end
        chk("stream_budget", 32'(got), 32'(nbits));
    endtask

    task automatic finish_chk(output int done_cyc);
        done_cyc = cyc;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("done_valid", 32'(bus.sout_valid), 32'd0);
        tick();
        bus.enable = 1'b0;
        chk("done_single", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int d1, d2;
        bus.enable     = 1'b0;
        bus.data       = '0;
        bus.sout_ready = 1'b0;

        // Test 1: asynchronous reset mid-cycle (no clock edge between 10 and 20 ns).
        #15 rst_n = 1'b0;
        #1;
        chk("rst_out", 32'(bus.out), 32'h00);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.sout_valid), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sout", 32'(bus.sout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Test 2: AA with ready held high.
        load(8'hAA);
        stream(0, 1'b0, W);
        finish_chk(d1);
        chk("t2_out", 32'(bus.out), 32'hAA);

        // Test 3: 55 with ready stalls.
        load(8'h55);
        stream(1, 1'b0, W);
        finish_chk(d1);

        // Test 4: loads while busy are ignored, including in the DONE cycle.
        load(8'hAA);
        stream(0, 1'b1, W);
        chk("t4_out_busy", 32'(bus.out), 32'hAA);
        finish_chk(d1);
        chk("t4_out_idle", 32'(bus.out), 32'hAA);
        tick();
        chk("t4_no_reload", 32'(bus.busy), 32'd0);

        // Test 5: reset after 3 bits aborts the transfer.
        load(8'h55);
        stream(0, 1'b0, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(bus.sout_valid), 32'd0);
        chk("abort_out", 32'(bus.out), 32'h00);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        exp_q.delete();
        tick();
        chk("abort_no_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", 32'(bus.done), 32'd0);
        load(8'hAA);
        stream(0, 1'b0, W);
        finish_chk(d1);

        // Test 6: X/0 enable while idle, then back-to-back words.
        for (int i = 0; i < 10; i++) begin
            bus.enable = (i < 5) ? 1'bx : 1'b0;
            bus.data   = 8'h3C;
            tick();
            chk("idle_x_busy", 32'(bus.busy), 32'd0);
            chk("idle_x_out", 32'(bus.out), 32'hAA);
        end
        bus.enable = 1'b0;
        load(8'hAA);
        stream(0, 1'b0, W);
        finish_chk(d1);
        load(8'h55);
        stream(0, 1'b0, W);
        finish_chk(d2);
        chk("b2b_spacing", 32'(d2 - d1), 32'(W + 2));
        chk("b2b_out", 32'(bus.out), 32'h55);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
